// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan path: segment patterns,
// scan-decoder FSM states and small anode-vector helpers.
package seven_seg_pkg;

  localparam int NUM_DIGITS  = 8;
  localparam int DIGIT_IDX_W = 3;

  // Active-low cathode patterns, bit 6 = CA ... bit 0 = CG
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // State codes kept as plain constants so older tools and dumps can match them
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SETTLE  = ST_SETTLE,
    HOLD    = ST_HOLD,
    CAPTURE = ST_CAPTURE
  } scan_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

  // Number of anodes currently driven low
  function automatic logic [3:0] low_count(input logic [7:0] an);
    return 4'($countones(~an));
  endfunction

  function automatic logic is_one_hot_low(input logic [7:0] an);
    return low_count(an) == 4'd1;
  endfunction

  // Position of the low anode; only meaningful for a one-hot-low vector
  function automatic logic [DIGIT_IDX_W-1:0] low_index(input logic [7:0] an);
    logic [DIGIT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) idx = DIGIT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational reverse lookup of an active-low cathode pattern to its hex value.
module seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] hex,
  output logic       is_blank,
  output logic       is_legal
);

  logic [15:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign match[gi] = (pattern == hex_to_seg(4'(gi)));
    end
  endgenerate

  // Encode the match vector; the 16 patterns are distinct so at most one bit is set
  always_comb begin
    hex = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (match[i]) hex = 4'(i);
    end
  end

  assign is_legal = |match;
  assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Recovers the hex digits shown by a multiplexed seven-segment driver by
// watching its anode strobes and cathodes, one register per digit.
module seven_segment_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  AN,
  input  logic [6:0]  SEG,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic [7:0]  seg_error,
  output logic        ghost_error,
  output logic        update_pulse,
  output logic [2:0]  update_idx
);

  localparam int              WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      SETTLE_MAX = 8'(SETTLE_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX     = WD_W'(TIMEOUT_CYCLES);

  logic [7:0]             an_meta_reg, an_sync_reg;
  logic [6:0]             seg_meta_reg, seg_sync_reg;
  logic [7:0]             stable_cnt_reg, stable_cnt_next;
  scan_state_e            state_reg, state_next;
  logic [WD_W-1:0]        wd_cnt_reg;
  logic                   changed, settled, capture, wd_expire, ghost_seen;
  logic [DIGIT_IDX_W-1:0] cap_idx;
  logic [3:0]             dec_hex;
  logic                   dec_blank, dec_legal;
  logic                   ghost_reg, update_pulse_reg;
  logic [DIGIT_IDX_W-1:0] update_idx_reg;
  logic [3:0]             digit_reg   [NUM_DIGITS];
  logic                   valid_reg   [NUM_DIGITS];
  logic                   seg_err_reg [NUM_DIGITS];

  // Two-flop synchronizers for the asynchronous display pins
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      an_meta_reg  <= '0;
      an_sync_reg  <= '0;
      seg_meta_reg <= '0;
      seg_sync_reg <= '0;
    end else begin
      an_meta_reg  <= AN;
      an_sync_reg  <= an_meta_reg;
      seg_meta_reg <= SEG;
      seg_sync_reg <= seg_meta_reg;
    end
  end

  // The synchronized value changes on the coming edge when the first stage disagrees with it
  assign changed = (an_meta_reg != an_sync_reg) || (seg_meta_reg != seg_sync_reg);

  // Stability count of the synchronized pins: cleared on change, saturating at SETTLE_MAX
  always_comb begin
    stable_cnt_next = stable_cnt_reg;
    if (changed)
      stable_cnt_next = 8'd0;
    else if (stable_cnt_reg != SETTLE_MAX)
      stable_cnt_next = stable_cnt_reg + 8'd1;
  end

  assign settled = (stable_cnt_next == SETTLE_MAX);

  // Register the stability count
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) stable_cnt_reg <= 8'd0;
    else             stable_cnt_reg <= stable_cnt_next;
  end

  // Scan FSM: wait for one strobe to settle, capture once, then hold until anything moves
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (is_one_hot_low(an_meta_reg)) state_next = SETTLE;
      end
      SETTLE: begin
        if (changed)      state_next = is_one_hot_low(an_meta_reg) ? SETTLE : IDLE;
        else if (settled) state_next = CAPTURE;
      end
      CAPTURE, HOLD: begin
        if (changed)                 state_next = is_one_hot_low(an_meta_reg) ? SETTLE : IDLE;
        else if (state_reg == CAPTURE) state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Register the FSM state
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  assign capture    = (state_reg == CAPTURE);
  assign cap_idx    = low_index(an_sync_reg);
  assign ghost_seen = (state_reg == IDLE) && settled && (low_count(an_sync_reg) >= 4'd2);

  seg_pattern_decoder u_decoder (
    .pattern  (seg_sync_reg),
    .hex      (dec_hex),
    .is_blank (dec_blank),
    .is_legal (dec_legal)
  );

  // Watchdog: cycles since the last capture, saturating at the timeout
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN)           wd_cnt_reg <= '0;
    else if (capture)          wd_cnt_reg <= '0;
    else if (wd_cnt_reg != WD_MAX) wd_cnt_reg <= wd_cnt_reg + 1'b1;
  end

  // Fires once, on the edge the watchdog reaches the timeout; a capture suppresses it
  assign wd_expire = !capture && (wd_cnt_reg == WD_MAX - 1'b1);

  // Capture strobe, its index and the sticky ghosting flag
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      update_pulse_reg <= 1'b0;
      update_idx_reg   <= '0;
      ghost_reg        <= 1'b0;
    end else begin
      update_pulse_reg <= capture;
      if (capture)    update_idx_reg <= cap_idx;
      if (ghost_seen) ghost_reg      <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic digit_hit;
      assign digit_hit = capture && (cap_idx == DIGIT_IDX_W'(gi));

      // Legal pattern loads the value, blank only drops valid, anything else flags an error
      always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
          digit_reg[gi]   <= 4'd0;
          valid_reg[gi]   <= 1'b0;
          seg_err_reg[gi] <= 1'b0;
        end else if (digit_hit) begin
          if (dec_legal) begin
            digit_reg[gi] <= dec_hex;
            valid_reg[gi] <= 1'b1;
          end else if (dec_blank) begin
            valid_reg[gi] <= 1'b0;
          end else begin
            seg_err_reg[gi] <= 1'b1;
          end
        end else if (wd_expire) begin
          valid_reg[gi] <= 1'b0;
        end
      end

      assign digits[4*gi +: 4] = digit_reg[gi];
      assign digit_valid[gi]   = valid_reg[gi];
      assign seg_error[gi]     = seg_err_reg[gi];
    end
  endgenerate

  assign ghost_error  = ghost_reg;
  assign update_pulse = update_pulse_reg;
  assign update_idx   = update_idx_reg;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Self-checking bench for seven_segment_scan_decoder: a cycle-level behavioural
// model built from stable-run lengths of the synchronized pins, compared on
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_seven_segment_scan_decoder;

  localparam int S = 16;
  localparam int T = 3000;

  logic        CLK100MHZ  = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic [7:0]  AN         = 8'hFF;
  logic [6:0]  SEG        = 7'h7F;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic [7:0]  seg_error;
  logic        ghost_error;
  logic        update_pulse;
  logic [2:0]  update_idx;

  seven_segment_scan_decoder #(
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLK100MHZ    (CLK100MHZ),
    .CPU_RESETN   (CPU_RESETN),
    .AN           (AN),
    .SEG          (SEG),
    .digits       (digits),
    .digit_valid  (digit_valid),
    .seg_error    (seg_error),
    .ghost_error  (ghost_error),
    .update_pulse (update_pulse),
    .update_idx   (update_idx)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  logic [6:0] pat_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observed capture log
  int pulse_cnt      = 0;
  int last_pulse_cyc = 0;
  int chg_cyc        = 0;
  int idx_log [$];

  // Model state
  bit          model_live = 1'b0;
  logic [14:0] m_meta = '0, m_sync = '0, m_prev = '0;
  int          run_len   = 1;
  int          since_cap = 0;
  int          m_val;
  bit          m_cap;
  logic [3:0]  m_digit [8];
  logic [7:0]  m_valid = '0, m_err = '0;
  logic        m_ghost = 1'b0, m_pulse = 1'b0;
  logic [2:0]  m_idx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 0..15 for a digit pattern, 16 for blank, -1 for anything else
  function automatic int seg_value(input logic [6:0] p);
    if (p == 7'b1111111) return 16;
    for (int i = 0; i < 16; i++) if (pat_tab[i] == p) return i;
    return -1;
  endfunction

  function automatic int count_low(input logic [7:0] an);
    int n = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) n++;
    return n;
  endfunction

  function automatic logic [2:0] low_pos(input logic [7:0] an);
    logic [2:0] p = '0;
    for (int i = 0; i < 8; i++) if (!an[i]) p = 3'(i);
    return p;
  endfunction

  function automatic logic [31:0] model_digits();
    logic [31:0] d = '0;
    for (int i = 0; i < 8; i++) d[4*i +: 4] = m_digit[i];
    return d;
  endfunction

  // Model: a capture happens the edge after the synchronized pins have held a
  // one-hot-low strobe for S+1 consecutive edges
  always @(posedge CLK100MHZ) begin
    cyc++;
    if (!CPU_RESETN) begin
      model_live = 1'b1;
      m_meta = '0; m_sync = '0; run_len = 1; since_cap = 0;
      for (int i = 0; i < 8; i++) m_digit[i] = 4'd0;
      m_valid = '0; m_err = '0; m_ghost = 1'b0; m_pulse = 1'b0; m_idx = '0;
    end else begin
      m_prev = m_sync;
      m_cap  = (count_low(m_prev[14:7]) == 1) && (run_len == S + 1);
      m_sync = m_meta;
      m_meta = {AN, SEG};
      if (m_sync == m_prev) begin
        if (run_len < S + 2) run_len++;
      end else begin
        run_len = 1;
      end
      if (count_low(m_sync[14:7]) >= 2 && run_len >= S + 1) m_ghost = 1'b1;
      m_pulse = m_cap;
      if (m_cap) begin
        m_idx = low_pos(m_prev[14:7]);
        m_val = seg_value(m_prev[6:0]);
        if (m_val == 16)    m_valid[m_idx] = 1'b0;
        else if (m_val < 0) m_err[m_idx]   = 1'b1;
        else begin
          m_digit[m_idx] = 4'(m_val);
          m_valid[m_idx] = 1'b1;
        end
        since_cap = 0;
      end else if (since_cap < T) begin
        since_cap++;
        if (since_cap == T) m_valid = '0;
      end
    end
  end

  // Per-cycle compare against the model, and capture logging
  always @(negedge CLK100MHZ) begin
    if (model_live) begin
      chk("cyc_digits", digits, model_digits());
      chk("cyc_valid", {24'd0, digit_valid}, {24'd0, m_valid});
      chk("cyc_seg_error", {24'd0, seg_error}, {24'd0, m_err});
      chk("cyc_ghost", {31'd0, ghost_error}, {31'd0, m_ghost});
      chk("cyc_pulse", {31'd0, update_pulse}, {31'd0, m_pulse});
      if (m_pulse) chk("cyc_idx", {29'd0, update_idx}, {29'd0, m_idx});
    end
    if (update_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      idx_log.push_back(int'(update_idx));
      $display("capture cyc=%0d idx=%0d digits=%h valid=%b seg_err=%b",
               cyc, update_idx, digits, digit_valid, seg_error);
    end
  end

  task automatic hold(input logic [7:0] an, input logic [6:0] seg, input int n);
    @(negedge CLK100MHZ);
    AN = an;
    SEG = seg;
    chg_cyc = cyc;
    repeat (n) @(negedge CLK100MHZ);
    #1;
  endtask

  int base;

  initial begin
    // Reset state
    repeat (5) @(negedge CLK100MHZ);
    #1;
    chk("reset_digits", digits, 32'h0);
    chk("reset_valid", {24'd0, digit_valid}, 32'h0);
    chk("reset_seg_error", {24'd0, seg_error}, 32'h0);
    chk("reset_ghost", {31'd0, ghost_error}, 32'h0);
    chk("reset_pulse", {31'd0, update_pulse}, 32'h0);
    @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    repeat (4) @(negedge CLK100MHZ);

    // Single digit 3 on anode 0
    base = pulse_cnt;
    idx_log.delete();
    hold(8'hFE, 7'b0000110, 40);
    chk("t1_pulses", pulse_cnt - base, 1);
    chk("t1_idx", idx_log.size() > 0 ? idx_log[0] : -1, 0);
    chk("t1_latency", last_pulse_cyc - chg_cyc, S + 3);
    chk("t1_digit0", {28'd0, digits[3:0]}, 32'h3);
    chk("t1_valid", {24'd0, digit_valid}, 32'h01);

    // Full scan 1..8 across digits 0..7
    base = pulse_cnt;
    idx_log.delete();
    for (int d = 0; d < 8; d++) hold(~(8'h01 << d), pat_tab[d + 1], 30);
    hold(8'hFF, 7'h7F, 10);
    chk("scan_pulses", pulse_cnt - base, 8);
    for (int i = 0; i < idx_log.size(); i++) chk("scan_idx_order", idx_log[i], i);
    chk("scan_digits", digits, 32'h87654321);
    chk("scan_valid", {24'd0, digit_valid}, 32'hFF);

    // Cathodes toggling faster than the settle time, then held
    base = pulse_cnt;
    for (int t = 0; t < 6; t++) hold(8'hFE, (t % 2 == 1) ? pat_tab[5] : pat_tab[6], 9);
    chk("toggle_no_pulse", pulse_cnt - base, 0);
    hold(8'hFE, pat_tab[9], 40);
    chk("toggle_one_pulse", pulse_cnt - base, 1);
    chk("toggle_latency", last_pulse_cyc - chg_cyc, S + 3);
    chk("toggle_digits", digits, 32'h87654329);

    // Illegal pattern on digit 2, blank on digit 5
    base = pulse_cnt;
    hold(8'hFB, 7'b1010101, 40);
    chk("illegal_pulse", pulse_cnt - base, 1);
    chk("illegal_seg_error", {24'd0, seg_error}, 32'h04);
    chk("illegal_digit2", {28'd0, digits[11:8]}, 32'h3);
    chk("illegal_valid", {24'd0, digit_valid}, 32'hFF);
    base = pulse_cnt;
    hold(8'hDF, 7'b1111111, 40);
    chk("blank_pulse", pulse_cnt - base, 1);
    chk("blank_valid", {24'd0, digit_valid}, 32'hDF);
    chk("blank_seg_error", {24'd0, seg_error}, 32'h04);
    chk("blank_digits", digits, 32'h87654329);

    // Two anodes low, then a long silence for the watchdog
    base = pulse_cnt;
    hold(8'hFC, pat_tab[8], 40);
    chk("ghost_flag", {31'd0, ghost_error}, 32'h1);
    chk("ghost_no_pulse", pulse_cnt - base, 0);
    hold(8'hFF, 7'h7F, T);
    chk("timeout_valid", {24'd0, digit_valid}, 32'h0);
    chk("timeout_digits", digits, 32'h87654329);
    chk("timeout_seg_error", {24'd0, seg_error}, 32'h04);
    chk("timeout_ghost", {31'd0, ghost_error}, 32'h1);

    // Reset asserted on the cycle before the capture
    base = pulse_cnt;
    @(negedge CLK100MHZ);
    AN = 8'hFE;
    SEG = pat_tab[4];
    chg_cyc = cyc;
    repeat (17) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b0;
    @(negedge CLK100MHZ);
    #1;
    chk("abort_digits", digits, 32'h0);
    chk("abort_valid", {24'd0, digit_valid}, 32'h0);
    chk("abort_seg_error", {24'd0, seg_error}, 32'h0);
    chk("abort_ghost", {31'd0, ghost_error}, 32'h0);
    chk("abort_pulse", {31'd0, update_pulse}, 32'h0);
    CPU_RESETN = 1'b1;
    repeat (5) @(negedge CLK100MHZ);
    #1;
    chk("abort_no_pulse", pulse_cnt - base, 0);
    repeat (30) @(negedge CLK100MHZ);
    #1;
    chk("after_reset_pulse", pulse_cnt - base, 1);
    chk("after_reset_digits", digits, 32'h00000004);
    chk("after_reset_valid", {24'd0, digit_valid}, 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Run-time bound
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL run_timeout: simulation did not complete at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "run timeout");
  end

endmodule

// File: doc/seven_segment_scan_decoder.md
# seven_segment_scan_decoder

Receive-side counterpart to the multiplexed seven-segment display driver. The block samples the scanned anode strobes and cathode lines, and waits for each strobe to settle. It then decodes the active-low segment pattern back to a 4-bit hex value and keeps one register per digit. It is used in loopback and self-test builds: the driver's AN and CA..CG outputs are wired here, and the recovered digits go to the checker logic or to LEDs.

## Interface
Parameters:
- SETTLE_CYCLES, 16: consecutive cycles that the synchronized AN/SEG must be unchanged before a capture; legal range 1..255.
- TIMEOUT_CYCLES, 1_000_000: cycles with no capture after which all digit_valid bits clear.

Ports:
- CLK100MHZ  in  1  sole clock, 100 MHz.
- CPU_RESETN  in  1  reset, synchronous and active-low.
- AN  in  8  anode strobes, active-low, asynchronous to the clock.
- SEG  in  7  cathodes {CA,CB,CC,CD,CE,CF,CG}, bit 6 = CA, active-low, asynchronous.
- digits  out  32  recovered values, digit i at [4i+3:4i].
- digit_valid  out  8  digit i holds a decoded non-blank value.
- seg_error  out  8  sticky flag: an illegal pattern was seen on digit i.
- ghost_error  out  1  sticky flag: more than one anode was low while stable.
- update_pulse  out  1  one-cycle strobe on each capture.
- update_idx  out  3  digit index of the current capture; valid only with update_pulse.

## Operation
- Synchronization: AN and SEG each pass through a two-flop synchronizer. All of the following logic uses the synchronized values (sAN, sSEG).
- Stability counter:
  - Resets to 0 on any cycle where sAN or sSEG differs from its previous value.
  - Otherwise increments, saturating at SETTLE_CYCLES.
- FSM states:
  - IDLE: sAN is not one-hot-low. All-high means blanking and is ignored. If more than one bit is low and the count reaches SETTLE_CYCLES, set ghost_error and stay in IDLE.
  - SETTLE: exactly one bit of sAN is low. When the count reaches SETTLE_CYCLES, go to CAPTURE. Any change restarts the count; if sAN is no longer one-hot-low, go to IDLE.
  - CAPTURE: lasts one cycle. Decode sSEG and write the result for idx = position of the low anode. Assert update_pulse with update_idx = idx. Then go to HOLD.
  - HOLD: no re-capture. Any change in sAN or sSEG returns to SETTLE if sAN is one-hot-low, otherwise to IDLE.
- Decode, active-low, CA..CG. Every legal pattern sets digit_valid[idx]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blank pattern 1111111: clear digit_valid[idx]; digits[idx] keeps its old value; update_pulse still asserts; no error is flagged.
- Any other pattern: set seg_error[idx]. digits[idx] and digit_valid[idx] are unchanged. update_pulse still asserts.
- Watchdog:
  - Counts cycles since the last CAPTURE.
  - At TIMEOUT_CYCLES, clear all digit_valid bits, then stay saturated.
  - A capture restarts the watchdog.
  - The watchdog does not touch digits or the error flags.
- Reset (CPU_RESETN low at a clock edge):
  - digits=0, digit_valid=0, seg_error=0, ghost_error=0, update_pulse=0, update_idx=0.
  - FSM goes to IDLE; all counters and synchronizers clear.
  - Reset during SETTLE or CAPTURE aborts the capture with no partial write.
  - Reset takes priority over every other event.

## Timing
- Latency: pins change at edge k and then stay stable. The first synchronized new value is at k+2. CAPTURE, and therefore update_pulse, occurs in the cycle after edge k+2+SETTLE_CYCLES, giving SETTLE_CYCLES+3 edges end to end.
- digits, digit_valid and seg_error update on the same edge that raises update_pulse.
- Minimum anode dwell for a capture is SETTLE_CYCLES+3 cycles. The driver's 100_000-cycle dwell is far above this.
- Watchdog clear and capture on the same cycle: the capture wins, the watchdog restarts, and digit_valid[idx] follows the decode result.
- All outputs are registered.

## Structure
- Package seven_seg_pkg holds:
  - localparams for the 16 segment patterns and SEG_BLANK;
  - the FSM state enum (IDLE, SETTLE, HOLD, CAPTURE);
  - the digit index width.
  - The display driver side reuses the same patterns.
- Sub-module seg_pattern_decoder is combinational: 7-bit pattern in; hex[3:0], is_blank and is_legal out.
- Top level contains the synchronizers, stability counter, FSM, digit register file and watchdog.

## Test plan
- Reset, then AN=11111110, SEG=0000110 held for 40 cycles → update_pulse exactly once, update_idx=0, digits[3:0]=3, digit_valid=00000001.
- Scan all 8 digits with patterns for 1,2,...,8, dwell 30 cycles each → digits=32'h87654321, digit_valid=FF, 8 pulses with idx 0..7 in order.
- SEG toggles every 10 cycles with SETTLE_CYCLES=16 → no update_pulse; after the toggling stops, one capture SETTLE_CYCLES+3 cycles later.
- Illegal pattern 1010101 on digit 2 → seg_error=00000100, digits[11:8] unchanged; SEG_BLANK on digit 5 → digit_valid[5]=0, seg_error unchanged.
- AN=11111100 held 40 cycles → ghost_error=1, no update_pulse; then no strobe at all for TIMEOUT_CYCLES → digit_valid=00.
- CPU_RESETN low on the cycle before CAPTURE → no update_pulse, all outputs 0 on the next edge.
